pipelined_shifter: RTL

Parametrised, pipelined shift/rotate unit with a valid/ready handshake on both sides. It replaces chains of fixed-amount shift instances: one instance takes a runtime shift amount and a mode, and processes one amount bit per pipeline stage. It sustains one operation per clock. It sits between datapath producers and consumers that need variable shifts without a long combinational path.

---
 rtl/pipelined_shifter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: variable shift/rotate unit. Pipeline stage k applies a
// shift of 2^k when bit k of the amount is set. Both sides use valid/ready,
// and the pipeline sustains one operation per clock.
module pipelined_shifter #(
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_in_valid,
    output logic                       io_in_ready,
    input  logic [WIDTH-1:0]           io_in_data,
    input  logic [$clog2(WIDTH)-1:0]   io_in_amt,
    input  logic [1:0]                 io_in_mode,
    output logic                       io_out_valid,
    input  logic                       io_out_ready,
    output logic [WIDTH-1:0]           io_out_data,
    output logic                       io_out_zero
);

    localparam int AW  = $clog2(WIDTH);
    localparam int LAT = AW;

    localparam logic [1:0] MODE_SLL = 2'd0;
    localparam logic [1:0] MODE_SRL = 2'd1;
    localparam logic [1:0] MODE_SRA = 2'd2;

    // One shift level. sh is a constant power of two below WIDTH, so the
    // ROL wrap term never shifts by the full width.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic             en,
        input int               sh
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        r    = d;
        fill = ~({WIDTH{1'b1}} >> sh);
        if (en) begin
            case (m)
                MODE_SLL: r = d << sh;
                MODE_SRL: r = d >> sh;
                MODE_SRA: r = (d >> sh) | (fill & {WIDTH{d[WIDTH-1]}});
                default:  r = (d << sh) | (d >> (WIDTH - sh));
            endcase
        end
        return r;
    endfunction

    logic [LAT-1:0]   v_q;
    logic [WIDTH-1:0] data_q   [LAT];
    logic [AW-1:0]    amt_q    [LAT];
    logic [1:0]       mode_q   [LAT];
    logic             zero_q;

    logic [LAT-1:0]   adv;
    logic [LAT-1:0]   load;
    logic [WIDTH-1:0] lvl      [LAT];
    logic [AW-1:0]    amt_src  [LAT];
    logic [1:0]       mode_src [LAT];
    logic             in_fire;

    // A valid stage advances when the consumer takes the head or a bubble
    // exists anywhere above it, since every stage in between then moves too.
    always_comb begin : adv_calc
        logic hole;
        adv = '0;
        for (int k = 0; k < LAT; k++) begin
            hole = 1'b0;
            for (int j = k + 1; j < LAT; j++) begin
                hole = hole | ~v_q[j];
            end
            adv[k] = v_q[k] & (io_out_ready | hole);
        end
    end

    assign io_in_ready = !reset && (!v_q[0] || adv[0]);
    assign in_fire     = io_in_valid && io_in_ready;

    // Per-stage load enables and next values, each shifted by that stage's level.
    always_comb begin
        load        = '0;
        load[0]     = in_fire;
        lvl[0]      = shift_level(io_in_data, io_in_mode, io_in_amt[0], 1);
        amt_src[0]  = io_in_amt;
        mode_src[0] = io_in_mode;
        for (int k = 1; k < LAT; k++) begin
            load[k]     = adv[k-1];
            lvl[k]      = shift_level(data_q[k-1], mode_q[k-1], amt_q[k-1][k], 1 << k);
            amt_src[k]  = amt_q[k-1];
            mode_src[k] = mode_q[k-1];
        end
    end

    // Stage registers: load on upstream advance, drop valid when leaving
    // without a replacement, and otherwise hold every field.
    always_ff @(posedge clock) begin
        if (reset) begin
            v_q    <= '0;
            zero_q <= 1'b1;
            for (int k = 0; k < LAT; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                if (load[k]) begin
                    v_q[k]    <= 1'b1;
                    data_q[k] <= lvl[k];
                    amt_q[k]  <= amt_src[k];
                    mode_q[k] <= mode_src[k];
                end else if (adv[k]) begin
                    v_q[k] <= 1'b0;
                end
            end
            if (load[LAT-1]) begin
                zero_q <= (lvl[LAT-1] == '0);
            end
        end
    end

    assign io_out_valid = v_q[LAT-1];
    assign io_out_data  = data_q[LAT-1];
    assign io_out_zero  = zero_q;

endmodule
